// File: rtl/sap_ram16x8_if.sv
`default_nettype none
// ============================================================================
//  Module      : sap_ram16x8_if
//  Description : Bus bundle for the 16x8 SAP memory. It carries the run-mode
//                read/write port that the controller and MAR drive, the
//                nibble-serial loader inputs, and the status outputs.
//                master = controller / test driver, slave = the memory.
//  Signals     : addr[3:0]      run-mode address (from MAR)
//                prog           1 = program mode, 0 = run mode
//                nib_in[3:0]    loader data nibble
//                nib_stb        loader nibble strobe (one cycle)
//                we, d_in[7:0]  run-mode write enable / write data
//                re             run-mode read enable
//                d_out[7:0]     registered read data
//                d_oe           bus drive enable for d_out
//                prog_addr[3:0] loader write address
//                prog_busy      loader active
//                load_done      pulse after address 15 is loaded
//                prog_err       sticky strobe-during-write error
//  Revision    : 1.0  initial release
// ============================================================================
interface sap_ram16x8_if;
    logic [3:0] addr;
    logic       prog;
    logic [3:0] nib_in;
    logic       nib_stb;
    logic       we;
    logic [7:0] d_in;
    logic       re;
    logic [7:0] d_out;
    logic       d_oe;
    logic [3:0] prog_addr;
    logic       prog_busy;
    logic       load_done;
    logic       prog_err;

    modport master (
        output addr, prog, nib_in, nib_stb, we, d_in, re,
        input  d_out, d_oe, prog_addr, prog_busy, load_done, prog_err
    );

    modport slave (
        input  addr, prog, nib_in, nib_stb, we, d_in, re,
        output d_out, d_oe, prog_addr, prog_busy, load_done, prog_err
    );
endinterface
`default_nettype wire

// File: rtl/sap_ram16x8.sv
`default_nettype none
// ============================================================================
//  Module      : sap_ram16x8
//  Description : 16-word x 8-bit data/program memory for the SAP datapath.
//                Run mode: registered reads onto the bus and writes from it,
//                addressed by the MAR. Program mode: a nibble-serial loader
//                FSM (IDLE/HI/LO/WRITE) fills memory from the 4-bit pins with
//                an auto-incrementing address.
//  Ports       : clk   system clock, rising edge
//                clr   synchronous active-high clear (wipes memory too)
//                bus   sap_ram16x8_if.slave (run port, loader, status)
//  Revision    : 1.0  initial release
// ============================================================================
module sap_ram16x8 (
    input  logic                clk,
    input  logic                clr,
    sap_ram16x8_if.slave        bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_hi    = 2'd1;
    localparam logic [1:0] c_st_lo    = 2'd2;
    localparam logic [1:0] c_st_write = 2'd3;

    localparam int         c_depth    = 16;

    logic [7:0] r_mem [c_depth];
    logic [1:0] r_state;
    logic [3:0] r_hi;
    logic [3:0] r_lo;
    logic [3:0] r_prog_addr;
    logic [7:0] r_d_out;
    logic       r_d_oe;
    logic       r_load_done;
    logic       r_prog_err;

    // Run port is live only when the loader is parked and prog is low; this
    // also suppresses a read issued in the same cycle prog rises.
    logic       w_run_ok;
    logic       w_run_wr;
    logic       w_run_rd;

    assign w_run_ok = (r_state == c_st_idle) & ~bus.prog;
    assign w_run_wr = w_run_ok & bus.we;
    assign w_run_rd = w_run_ok & bus.re;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_state     <= c_st_idle;
            r_hi        <= 4'h0;
            r_lo        <= 4'h0;
            r_prog_addr <= 4'h0;
            r_d_out     <= 8'h00;
            r_d_oe      <= 1'b0;
            r_load_done <= 1'b0;
            r_prog_err  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_d_oe      <= w_run_rd;

            // Read samples the pre-edge contents, so a same-address
            // read/write returns the old word.
            if (w_run_rd) begin
                r_d_out <= r_mem[bus.addr];
            end
            if (w_run_wr) begin
                r_mem[bus.addr] <= bus.d_in;
            end

            case (r_state)
                c_st_idle: begin
                    if (bus.prog) begin
                        r_state     <= c_st_hi;
                        r_prog_addr <= 4'h0;
                        r_prog_err  <= 1'b0;
                    end
                end
                c_st_hi: begin
                    if (!bus.prog) begin
                        r_state <= c_st_idle;
                    end else if (bus.nib_stb) begin
                        r_hi    <= bus.nib_in;
                        r_state <= c_st_lo;
                    end
                end
                c_st_lo: begin
                    // Leaving here abandons the captured high nibble.
                    if (!bus.prog) begin
                        r_state <= c_st_idle;
                    end else if (bus.nib_stb) begin
                        r_lo    <= bus.nib_in;
                        r_state <= c_st_write;
                    end
                end
                c_st_write: begin
                    // Commit is unconditional: a byte whose low nibble was
                    // accepted always lands, even if prog drops now.
                    r_mem[r_prog_addr] <= {r_hi, r_lo};
                    r_prog_addr        <= r_prog_addr + 4'd1;
                    r_load_done        <= (r_prog_addr == 4'hF);
                    if (bus.nib_stb) begin
                        r_prog_err <= 1'b1;
                    end
                    r_state <= bus.prog ? c_st_hi : c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.d_out     = r_d_out;
    assign bus.d_oe      = r_d_oe;
    assign bus.prog_addr = r_prog_addr;
    assign bus.prog_busy = (r_state != c_st_idle);
    assign bus.load_done = r_load_done;
    assign bus.prog_err  = r_prog_err;

endmodule
`default_nettype wire

// File: tb/tb_sap_ram16x8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap_ram16x8
//  Description : Directed self-checking bench for sap_ram16x8. Inputs change
//                1 ns after a rising edge and outputs are sampled there too.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sap_ram16x8;

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    sap_ram16x8_if bus ();

    sap_ram16x8 dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.addr    = 4'h0;
        bus.prog    = 1'b0;
        bus.nib_in  = 4'h0;
        bus.nib_stb = 1'b0;
        bus.we      = 1'b0;
        bus.d_in    = 8'h00;
        bus.re      = 1'b0;
    endtask

    // Run-mode read of one address; returns the data seen after the edge.
    task automatic run_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        bus.re   = 1'b1;
        bus.addr = a;
        tick();
        bus.re   = 1'b0;
        checks++;
        if (bus.d_out !== exp || bus.d_oe !== 1'b1) begin
            errors++;
            $display("FAIL %s addr=%0d: d_out=%h d_oe=%b, expected d_out=%h d_oe=1",
                     name, a, bus.d_out, bus.d_oe, exp);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        checks++;
        if (bus.d_out !== 8'h00 || bus.d_oe !== 1'b0 || bus.prog_addr !== 4'h0 ||
            bus.prog_busy !== 1'b0 || bus.load_done !== 1'b0 || bus.prog_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: d_out=%h d_oe=%b pa=%h busy=%b done=%b err=%b, expected all zero",
                     bus.d_out, bus.d_oe, bus.prog_addr, bus.prog_busy, bus.load_done, bus.prog_err);
        end
        for (int i = 0; i < 16; i++) begin
            run_read(4'(i), 8'h00, "reset_read");
        end
        tick();
        checks++;
        if (bus.d_oe !== 1'b0 || bus.d_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_oe_drop: d_oe=%b d_out=%h, expected 0 / 00", bus.d_oe, bus.d_out);
        end
    endtask

    task automatic test_full_load();
        int         done_cnt;
        logic [3:0] n;
        logic [7:0] exp;
        done_cnt = 0;
        bus.prog = 1'b1;
        tick();
        checks++;
        if (bus.prog_busy !== 1'b1 || bus.prog_addr !== 4'h0) begin
            errors++;
            $display("FAIL load_enter: busy=%b pa=%h, expected 1 / 0", bus.prog_busy, bus.prog_addr);
        end
        for (int i = 0; i < 16; i++) begin
            n = 4'(i);
            bus.nib_stb = 1'b1;
            bus.nib_in  = n;
            tick();
            if (bus.load_done === 1'b1) done_cnt++;
            bus.nib_in  = ~n;
            tick();
            if (bus.load_done === 1'b1) done_cnt++;
            bus.nib_stb = 1'b0;
            tick();
            if (bus.load_done === 1'b1) done_cnt++;
            if (i == 14) begin
                checks++;
                if (bus.prog_addr !== 4'hF || done_cnt != 0) begin
                    errors++;
                    $display("FAIL load_addr14: pa=%h done_cnt=%0d, expected F / 0", bus.prog_addr, done_cnt);
                end
            end
        end
        checks++;
        if (bus.load_done !== 1'b1 || bus.prog_addr !== 4'h0 || done_cnt != 1) begin
            errors++;
            $display("FAIL load_done_pulse: done=%b pa=%h cnt=%0d, expected 1 / 0 / 1",
                     bus.load_done, bus.prog_addr, done_cnt);
        end
        tick();
        checks++;
        if (bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL load_done_single: done=%b, expected 0", bus.load_done);
        end
        bus.prog = 1'b0;
        tick();
        checks++;
        if (bus.prog_busy !== 1'b0 || bus.prog_err !== 1'b0) begin
            errors++;
            $display("FAIL load_exit: busy=%b err=%b, expected 0 / 0", bus.prog_busy, bus.prog_err);
        end
        run_read(4'd3, 8'h3C, "load_mem3");
        for (int i = 0; i < 16; i++) begin
            n   = 4'(i);
            exp = {n, ~n};
            run_read(n, exp, "load_readback");
        end
    endtask

    task automatic test_abort();
        bus.prog = 1'b1;
        tick();
        bus.nib_stb = 1'b1;
        bus.nib_in  = 4'hA;
        tick();
        bus.nib_stb = 1'b0;
        bus.prog    = 1'b0;
        tick();
        checks++;
        if (bus.prog_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b, expected 0", bus.prog_busy);
        end
        bus.prog = 1'b1;
        tick();
        bus.nib_stb = 1'b1;
        bus.nib_in  = 4'h1;
        tick();
        bus.nib_in  = 4'h2;
        tick();
        bus.nib_stb = 1'b0;
        tick();
        checks++;
        if (bus.prog_addr !== 4'h1) begin
            errors++;
            $display("FAIL abort_addr: pa=%h, expected 1", bus.prog_addr);
        end
        bus.prog = 1'b0;
        tick();
        run_read(4'd0, 8'h12, "abort_mem0");
        run_read(4'd1, 8'h1E, "abort_mem1");
    endtask

    task automatic test_collision();
        bus.we   = 1'b1;
        bus.addr = 4'd5;
        bus.d_in = 8'h11;
        tick();
        bus.re   = 1'b1;
        bus.d_in = 8'h99;
        tick();
        bus.we   = 1'b0;
        bus.re   = 1'b0;
        checks++;
        if (bus.d_out !== 8'h11 || bus.d_oe !== 1'b1) begin
            errors++;
            $display("FAIL collision_old: d_out=%h d_oe=%b, expected 11 / 1", bus.d_out, bus.d_oe);
        end
        run_read(4'd5, 8'h99, "collision_new");
        bus.addr = 4'd0;
        tick();
        checks++;
        if (bus.d_out !== 8'h99 || bus.d_oe !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: d_out=%h d_oe=%b, expected 99 / 0", bus.d_out, bus.d_oe);
        end
    endtask

    task automatic test_strobe_write();
        bus.prog = 1'b1;
        tick();
        bus.nib_stb = 1'b1;
        bus.nib_in  = 4'h4;
        tick();
        bus.nib_in  = 4'h5;
        tick();
        bus.nib_in  = 4'h6;
        tick();
        bus.nib_stb = 1'b0;
        checks++;
        if (bus.prog_err !== 1'b1 || bus.prog_addr !== 4'h1) begin
            errors++;
            $display("FAIL strobe_err_set: err=%b pa=%h, expected 1 / 1", bus.prog_err, bus.prog_addr);
        end
        bus.prog = 1'b0;
        tick();
        checks++;
        if (bus.prog_err !== 1'b1) begin
            errors++;
            $display("FAIL strobe_err_sticky: err=%b, expected 1", bus.prog_err);
        end
        run_read(4'd0, 8'h45, "strobe_mem0");
        run_read(4'd1, 8'h1E, "strobe_mem1");
        bus.prog = 1'b1;
        tick();
        checks++;
        if (bus.prog_err !== 1'b0) begin
            errors++;
            $display("FAIL strobe_err_clear: err=%b, expected 0", bus.prog_err);
        end
        bus.prog = 1'b0;
        tick();
    endtask

    task automatic test_prog_ignores_run();
        bus.re   = 1'b1;
        bus.addr = 4'd7;
        tick();
        checks++;
        if (bus.d_oe !== 1'b1 || bus.d_out !== 8'h78) begin
            errors++;
            $display("FAIL ign_pre_read: d_oe=%b d_out=%h, expected 1 / 78", bus.d_oe, bus.d_out);
        end
        // prog rises with a read and write pending on address 2
        bus.prog = 1'b1;
        bus.we   = 1'b1;
        bus.d_in = 8'hFF;
        bus.addr = 4'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (bus.d_oe !== 1'b0 || bus.d_out !== 8'h78) begin
                errors++;
                $display("FAIL ign_oe cycle=%0d: d_oe=%b d_out=%h, expected 0 / 78", k, bus.d_oe, bus.d_out);
            end
        end
        bus.prog = 1'b0;
        bus.we   = 1'b0;
        bus.re   = 1'b0;
        tick();
        run_read(4'd2, 8'h2D, "ign_mem2");
        run_read(4'd0, 8'h45, "ign_mem0");
    endtask

    task automatic test_reset_midload();
        bus.prog = 1'b1;
        tick();
        bus.nib_stb = 1'b1;
        bus.nib_in  = 4'hC;
        tick();
        bus.nib_in  = 4'hD;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.nib_stb = 1'b0;
        bus.prog    = 1'b0;
        tick();
        checks++;
        if (bus.prog_busy !== 1'b0 || bus.prog_addr !== 4'h0) begin
            errors++;
            $display("FAIL midreset_state: busy=%b pa=%h, expected 0 / 0", bus.prog_busy, bus.prog_addr);
        end
        run_read(4'd0, 8'h00, "midreset_mem0");
        run_read(4'd9, 8'h00, "midreset_mem9");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr    = 1'b1;
        idle_inputs();
        test_reset();
        test_full_load();
        test_abort();
        test_collision();
        test_strobe_write();
        test_prog_ignores_run();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
